// File: rtl/segment_readback_pkg.sv
// Shared constants for the seven-segment readback monitor: active-low digit
// codes {g..a}, the tracker state encoding and a 4-digit BCD increment helper.
package segment_readback_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Decimal +1 over four BCD digits; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] val);
        logic [15:0] res;
        logic        carry;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (val[4*i +: 4] >= BCD_MAX) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = val[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*i +: 4] = val[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/segment_readback_seg_decode.sv
// Combinational seven-segment to BCD decoder; ok is low for any non-digit code.
module seg_decode
    import segment_readback_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       ok
);

    // Map each legal digit code to its BCD value, flag everything else.
    always_comb begin
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: begin
                digit = 4'd0;
                ok    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/segment_readback.sv
// Readback monitor: glitch-filters the four digit buses, decodes accepted
// patterns and checks that the displayed value advances as a decimal counter.
module segment_readback
    import segment_readback_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STEP_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [6:0]        segmen_digit_0,
    input  logic [6:0]        segmen_digit_1,
    input  logic [6:0]        segmen_digit_2,
    input  logic [6:0]        segmen_digit_3,
    input  logic              clear_err,
    output logic [3:0]        digit_0,
    output logic [3:0]        digit_1,
    output logic [3:0]        digit_2,
    output logic [3:0]        digit_3,
    output logic              digits_valid,
    output logic              pattern_err,
    output logic              step_err,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [7:0]        STAB_TGT  = 8'(STABLE_CYCLES);
    localparam logic [27:0]       BLANK4    = {4{SEG_BLANK}};
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_FULL = {STEP_W{1'b1}};

    logic [27:0]       samp_q, samp_d;
    logic [7:0]        stab_q, stab_d;
    logic [27:0]       last_acc_q, last_acc_d;
    state_e            state_q, state_d;
    logic [15:0]       digits_q, digits_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              serr_q, serr_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    logic [15:0] dec_val;
    logic [3:0]  dec_ok;
    logic        accept_s;
    logic [15:0] inc_val;

    for (genvar g = 0; g < 4; g++) begin : g_dec
        seg_decode u_dec (
            .seg   (samp_q[7*g +: 7]),
            .digit (dec_val[4*g +: 4]),
            .ok    (dec_ok[g])
        );
    end

    // Accept is evaluated on the already-registered sample, so it lags edge N by one cycle.
    assign accept_s = (stab_q == STAB_TGT) && (samp_q != last_acc_q);
    assign inc_val  = bcd4_inc(digits_q);

    // Sampling register and stability counter.
    always_comb begin
        samp_d = {segmen_digit_3, segmen_digit_2, segmen_digit_1, segmen_digit_0};
        stab_d = stab_q;
        if (samp_d != samp_q) begin
            stab_d = 8'd1;
        end else if (stab_q < STAB_TGT) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end
    end

    // Tracker: classify each accepted pattern and update digits, step count and flags.
    always_comb begin
        last_acc_d = last_acc_q;
        state_d    = state_q;
        digits_d   = digits_q;
        steps_d    = steps_q;
        if (clear_err) begin
            perr_d = 1'b0;
            serr_d = 1'b0;
        end else begin
            perr_d = perr_q;
            serr_d = serr_q;
        end
        if (accept_s) begin
            last_acc_d = samp_q;
            if (dec_ok != 4'b1111) begin
                perr_d = 1'b1;
            end else if (state_q == IDLE) begin
                digits_d = dec_val;
                state_d  = TRACK;
            end else if (dec_val == inc_val) begin
                digits_d = dec_val;
                if (steps_q != STEP_FULL) begin
                    steps_d = steps_q + STEP_ONE;
                end else begin
                    steps_d = steps_q;
                end
            end else if (dec_val == 16'h0000) begin
                digits_d = dec_val;
            end else begin
                digits_d = dec_val;
                serr_d   = 1'b1;
            end
        end else begin
            last_acc_d = last_acc_q;
        end
        valid_d = (state_d == TRACK);
    end

    // All state and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_q     <= BLANK4;
            stab_q     <= 8'd1;
            last_acc_q <= BLANK4;
            state_q    <= IDLE;
            digits_q   <= 16'h0000;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            steps_q    <= {STEP_W{1'b0}};
        end else begin
            samp_q     <= samp_d;
            stab_q     <= stab_d;
            last_acc_q <= last_acc_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            steps_q    <= steps_d;
        end
    end

    assign digit_0      = digits_q[3:0];
    assign digit_1      = digits_q[7:4];
    assign digit_2      = digits_q[11:8];
    assign digit_3      = digits_q[15:12];
    assign digits_valid = valid_q;
    assign pattern_err  = perr_q;
    assign step_err     = serr_q;
    assign step_count   = steps_q;

endmodule

// File: tb/tb_segment_readback.sv
// Self-checking bench for segment_readback with a value-level reference model.
module tb_segment_readback;

    localparam int S = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  seg0, seg1, seg2, seg3;
    logic        clear_err;
    logic [3:0]  digit_0, digit_1, digit_2, digit_3;
    logic        digits_valid, pattern_err, step_err;
    logic [15:0] step_count;
    logic [15:0] obs;

    segment_readback #(.STABLE_CYCLES(S), .STEP_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .segmen_digit_0(seg0), .segmen_digit_1(seg1),
        .segmen_digit_2(seg2), .segmen_digit_3(seg3),
        .clear_err(clear_err),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
        .digits_valid(digits_valid), .pattern_err(pattern_err),
        .step_err(step_err), .step_count(step_count)
    );

    always #5 CLK = ~CLK;
    assign obs = {digit_3, digit_2, digit_1, digit_0};

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [27:0] BLANK = 28'hFFFFFFF;

    int cmp = 0;
    int mism = 0;

    // Reference model state: displayed value as an integer
    int          m_val;
    bit          m_valid, m_perr, m_serr;
    int          m_steps;
    logic [27:0] m_last;

    function automatic logic [27:0] pat_of(input int v);
        return {seg_tab[(v/1000)%10], seg_tab[(v/100)%10], seg_tab[(v/10)%10], seg_tab[v%10]};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v/1000)%10), 4'((v/100)%10), 4'((v/10)%10), 4'(v%10)};
    endfunction

    task automatic model_reset();
        m_val = 0; m_valid = 0; m_perr = 0; m_serr = 0; m_steps = 0; m_last = BLANK;
    endtask

    task automatic model_apply(input logic [27:0] p);
        int v;
        int d;
        bit ok;
        if (p == m_last) return;
        m_last = p;
        v = 0;
        ok = 1;
        for (int k = 3; k >= 0; k--) begin
            d = -1;
            for (int j = 0; j < 10; j++) if (p[7*k +: 7] == seg_tab[j]) d = j;
            if (d < 0) ok = 0;
            else v = v * 10 + d;
        end
        if (!ok) m_perr = 1;
        else if (!m_valid) begin m_valid = 1; m_val = v; end
        else if (v == (m_val + 1) % 10000) begin
            m_val = v;
            if (m_steps < 65535) m_steps++;
        end
        else if (v == 0) m_val = 0;
        else begin m_val = v; m_serr = 1; end
    endtask

    task automatic drive(input logic [27:0] p);
        {seg3, seg2, seg1, seg0} = p;
    endtask

    task automatic hold_pat(input logic [27:0] p);
        @(negedge CLK);
        drive(p);
        model_apply(p);
        repeat (S + 2) @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        @(negedge CLK); clear_err = 1'b1;
        @(negedge CLK); clear_err = 1'b0;
        m_perr = 0; m_serr = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; clear_err = 1'b0; drive(BLANK);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        cmp++; if (obs !== 16'h0000) begin mism++; $display("FAIL reset_digits got %h want 0000", obs); end
        cmp++; if (digits_valid !== 1'b0) begin mism++; $display("FAIL reset_valid got %b want 0", digits_valid); end
        cmp++; if ({pattern_err, step_err} !== 2'b00) begin mism++; $display("FAIL reset_flags got %b want 00", {pattern_err, step_err}); end
        cmp++; if (step_count !== 16'd0) begin mism++; $display("FAIL reset_steps got %0d want 0", step_count); end
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_count();
        hold_pat(pat_of(0));
        cmp++; if (digits_valid !== 1'b1) begin mism++; $display("FAIL count_valid got %b want 1", digits_valid); end
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL count_first got %h want %h", obs, to_bcd(m_val)); end
        @(negedge CLK); drive(pat_of(1)); model_apply(pat_of(1));
        repeat (S) @(posedge CLK);
        #1;
        cmp++; if (obs !== to_bcd(0)) begin mism++; $display("FAIL latency_early got %h want 0000", obs); end
        @(posedge CLK);
        #1;
        cmp++; if (obs !== to_bcd(1)) begin mism++; $display("FAIL latency_edge got %h want 0001", obs); end
        hold_pat(pat_of(2));
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL count_digits got %h want %h", obs, to_bcd(m_val)); end
        cmp++; if (step_count !== 16'(m_steps)) begin mism++; $display("FAIL count_steps got %0d want %0d", step_count, m_steps); end
        cmp++; if ({pattern_err, step_err} !== {m_perr, m_serr}) begin mism++; $display("FAIL count_flags got %b want %b", {pattern_err, step_err}, {m_perr, m_serr}); end
    endtask

    task automatic test_wrap();
        hold_pat(pat_of(9));
        do_clear();
        hold_pat(pat_of(10));
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL wrap10_digits got %h want %h", obs, to_bcd(m_val)); end
        cmp++; if (step_count !== 16'(m_steps)) begin mism++; $display("FAIL wrap10_steps got %0d want %0d", step_count, m_steps); end
        cmp++; if (step_err !== 1'b0) begin mism++; $display("FAIL wrap10_err got %b want 0", step_err); end
        hold_pat(pat_of(9999));
        do_clear();
        hold_pat(pat_of(0));
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL wrap0_digits got %h want %h", obs, to_bcd(m_val)); end
        cmp++; if (step_count !== 16'(m_steps)) begin mism++; $display("FAIL wrap0_steps got %0d want %0d", step_count, m_steps); end
        cmp++; if (step_err !== 1'b0) begin mism++; $display("FAIL wrap0_err got %b want 0", step_err); end
    endtask

    task automatic test_step_err();
        hold_pat(pat_of(42));
        do_clear();
        hold_pat(pat_of(45));
        cmp++; if (step_err !== m_serr) begin mism++; $display("FAIL steperr_set got %b want %b", step_err, m_serr); end
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL steperr_digits got %h want %h", obs, to_bcd(m_val)); end
        @(negedge CLK); clear_err = 1'b1;
        @(posedge CLK);
        #1;
        m_perr = 0; m_serr = 0;
        cmp++; if (step_err !== 1'b0) begin mism++; $display("FAIL steperr_clear got %b want 0", step_err); end
        @(negedge CLK); clear_err = 1'b0;
        hold_pat(pat_of(0));
        cmp++; if ({obs, step_err} !== {to_bcd(m_val), m_serr}) begin mism++; $display("FAIL steperr_zero got %h/%b want %h/%b", obs, step_err, to_bcd(m_val), m_serr); end
    endtask

    task automatic test_glitch();
        hold_pat(pat_of(4));
        hold_pat(pat_of(5));
        @(negedge CLK); drive(pat_of(6));
        repeat (S - 1) @(posedge CLK);
        @(negedge CLK); drive(pat_of(5));
        repeat (S + 2) @(posedge CLK);
        #1;
        cmp++; if (obs !== to_bcd(m_val)) begin mism++; $display("FAIL glitch_digits got %h want %h", obs, to_bcd(m_val)); end
        cmp++; if (step_count !== 16'(m_steps)) begin mism++; $display("FAIL glitch_steps got %0d want %0d", step_count, m_steps); end
        hold_pat(pat_of(6));
        cmp++; if (step_count !== 16'(m_steps)) begin mism++; $display("FAIL glitch_after got %0d want %0d", step_count, m_steps); end
    endtask

    task automatic test_pattern_err();
        logic [27:0] p;
        logic [27:0] p2;
        p = pat_of(m_val);
        p[20:14] = 7'b1110110;
        hold_pat(p);
        cmp++; if (pattern_err !== m_perr) begin mism++; $display("FAIL perr_set got %b want %b", pattern_err, m_perr); end
        cmp++; if ({obs, step_count} !== {to_bcd(m_val), 16'(m_steps)}) begin mism++; $display("FAIL perr_hold got %h/%0d want %h/%0d", obs, step_count, to_bcd(m_val), m_steps); end
        p2 = p;
        p2[27:21] = 7'b0001000;
        @(negedge CLK); drive(p2); model_apply(p2);
        repeat (S) @(posedge CLK);
        @(negedge CLK); clear_err = 1'b1;
        @(posedge CLK);
        #1;
        m_serr = 0;
        cmp++; if (pattern_err !== m_perr) begin mism++; $display("FAIL perr_race got %b want %b", pattern_err, m_perr); end
        @(negedge CLK); clear_err = 1'b0;
        do_clear();
        cmp++; if (pattern_err !== 1'b0) begin mism++; $display("FAIL perr_clear got %b want 0", pattern_err); end
    endtask

    task automatic test_random();
        logic [27:0] p;
        int r;
        int k;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) p = pat_of((m_val + 1) % 10000);
            else if (r == 6) p = pat_of(0);
            else if (r == 7) p = pat_of($urandom_range(0, 9999));
            else if (r == 8) begin
                p = pat_of(m_val);
                k = $urandom_range(0, 3);
                p[7*k +: 7] = 7'($urandom);
            end
            else p = pat_of(9999);
            hold_pat(p);
            if (i % 8 == 7) do_clear();
            cmp++;
            if ({obs, digits_valid, pattern_err, step_err, step_count} !==
                {to_bcd(m_val), m_valid, m_perr, m_serr, 16'(m_steps)}) begin
                mism++;
                $display("FAIL random_%0d got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", i,
                         obs, digits_valid, pattern_err, step_err, step_count,
                         to_bcd(m_val), m_valid, m_perr, m_serr, m_steps);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [27:0] p;
        hold_pat(pat_of((m_val + 1) % 10000));
        p = pat_of(1234);
        if (p == m_last) p = pat_of(4321);
        @(negedge CLK); drive(p);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        model_reset();
        cmp++; if ({obs, digits_valid} !== 17'd0) begin mism++; $display("FAIL async_digits got %h/%b want 0000/0", obs, digits_valid); end
        cmp++; if ({pattern_err, step_err, step_count} !== 18'd0) begin mism++; $display("FAIL async_flags got %b%b/%0d want 00/0", pattern_err, step_err, step_count); end
        drive(BLANK);
        @(negedge CLK); RST = 1'b0;
        repeat (S + 3) @(posedge CLK);
        #1;
        cmp++; if ({obs, digits_valid, pattern_err} !== 18'd0) begin mism++; $display("FAIL blank_after got %h/%b/%b want 0000/0/0", obs, digits_valid, pattern_err); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_step_err();
        test_glitch();
        test_pattern_err();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
